// File: rtl/usb_pkg.sv
// usb_pkg: PID constants, packet field positions, FSM state type and
// packet builders shared by the host transaction engine.
package usb_pkg;

    localparam int PKT_W   = 99;
    localparam int PID_HI  = 98;
    localparam int PID_LO  = 91;
    localparam int ADDR_HI = 90;
    localparam int ADDR_LO = 84;
    localparam int ENDP_HI = 83;
    localparam int ENDP_LO = 80;
    localparam int DATA_HI = 90;
    localparam int DATA_LO = 27;

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TOK,
        S_TOK_WAIT,
        S_DATA,
        S_DATA_WAIT,
        S_WAIT_HS,
        S_WAIT_DATA,
        S_HS,
        S_HS_WAIT,
        S_DONE
    } usb_state_t;

    function automatic logic [PKT_W-1:0] pack_token(
        input logic [7:0] pid,
        input logic [6:0] addr,
        input logic [3:0] endp
    );
        logic [PKT_W-1:0] p;
        p = '0;
        p[PID_HI:PID_LO]   = pid;
        p[ADDR_HI:ADDR_LO] = addr;
        p[ENDP_HI:ENDP_LO] = endp;
        return p;
    endfunction

    function automatic logic [PKT_W-1:0] pack_data(
        input logic [7:0]  pid,
        input logic [63:0] payload
    );
        logic [PKT_W-1:0] p;
        p = '0;
        p[PID_HI:PID_LO]   = pid;
        p[DATA_HI:DATA_LO] = payload;
        return p;
    endfunction

    function automatic logic [PKT_W-1:0] pack_handshake(
        input logic [7:0] pid
    );
        logic [PKT_W-1:0] p;
        p = '0;
        p[PID_HI:PID_LO] = pid;
        return p;
    endfunction

endpackage

// File: rtl/usb_resp_timer.sv
// usb_resp_timer: 8-bit saturating response timer; timeout fires in
// the cycle the count steps up to TIMEOUT_CYC.
module usb_resp_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    assign timeout = en && (count == 8'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/usb_host_protocol.sv
// usb_host_protocol: host transaction engine issuing token/data/handshake
// packets to the encoder and interpreting decoded device responses.
module usb_host_protocol
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int MAX_RETRY   = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             txn_start,
    input  logic             txn_is_in,
    input  logic [6:0]       txn_addr,
    input  logic [3:0]       txn_endp,
    input  logic [63:0]      txn_data_out,
    output logic             busy,
    output logic             txn_done,
    output logic             txn_success,
    output logic [63:0]      txn_data_in,
    output logic [PKT_W-1:0] pkt_in,
    output logic             pkt_in_avail,
    input  logic             encoder_ready,
    input  logic [PKT_W-1:0] pkt_out,
    input  logic             pkt_out_avail,
    input  logic             data_good,
    input  logic             decoder_ready,
    output logic             re
);

    localparam int RW = $clog2(MAX_RETRY + 1);

    usb_state_t       state, state_n;
    logic             req_in, req_in_n;
    logic [6:0]       req_addr, req_addr_n;
    logic [3:0]       req_endp, req_endp_n;
    logic [63:0]      req_data, req_data_n;
    logic [RW-1:0]    retry, retry_n;
    logic [PKT_W-1:0] pkt_n;
    logic             avail_n;
    logic             seen_low, seen_low_n;
    logic             hs_nak, hs_nak_n;
    logic             success_n;
    logic [63:0]      data_in_n;
    logic             waiting, timeout, sent;
    logic             pid_ok, good, retry_ev;
    logic [3:0]       pid_lo;

    assign waiting  = (state == S_WAIT_HS) || (state == S_WAIT_DATA);
    assign re       = waiting;
    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign txn_done = (state == S_DONE);

    // a corrupt PID byte is handled exactly like a CRC failure
    assign pid_lo = pkt_out[PID_LO+3:PID_LO];
    assign pid_ok = pkt_out[PID_HI:PID_LO+4] == ~pid_lo;
    assign good   = data_good && pid_ok;
    assign sent   = !pkt_in_avail && seen_low && encoder_ready;

    logic unused_ok;
    assign unused_ok = &{1'b0, decoder_ready, pkt_out[DATA_LO-1:0]};

    usb_resp_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst_b),
        .clr    (!waiting),
        .en     (waiting),
        .timeout(timeout)
    );

    always_comb begin
        state_n    = state;
        req_in_n   = req_in;
        req_addr_n = req_addr;
        req_endp_n = req_endp;
        req_data_n = req_data;
        retry_n    = retry;
        pkt_n      = pkt_in;
        avail_n    = pkt_in_avail;
        seen_low_n = seen_low;
        hs_nak_n   = hs_nak;
        success_n  = txn_success;
        data_in_n  = txn_data_in;
        retry_ev   = 1'b0;
        if (pkt_in_avail && encoder_ready) avail_n = 1'b0;
        if (!pkt_in_avail && !encoder_ready) seen_low_n = 1'b1;
        unique case (state)
            S_IDLE: begin
                if (txn_start) begin
                    req_in_n   = txn_is_in;
                    req_addr_n = txn_addr;
                    req_endp_n = txn_endp;
                    req_data_n = txn_data_out;
                    retry_n    = RW'(1);
                    success_n  = 1'b0;
                    state_n    = S_TOK;
                end
            end
            S_TOK: begin
                pkt_n = pack_token(req_in ? PID_IN : PID_OUT,
                                   req_addr, req_endp);
                avail_n    = 1'b1;
                seen_low_n = 1'b0;
                state_n    = S_TOK_WAIT;
            end
            S_TOK_WAIT: begin
                if (sent) state_n = req_in ? S_WAIT_DATA : S_DATA;
            end
            S_DATA: begin
                pkt_n      = pack_data(PID_DATA0, req_data);
                avail_n    = 1'b1;
                seen_low_n = 1'b0;
                state_n    = S_DATA_WAIT;
            end
            S_DATA_WAIT: begin
                if (sent) state_n = S_WAIT_HS;
            end
            S_WAIT_HS: begin
                if (pkt_out_avail) begin
                    if (good && pid_lo == PID_ACK[3:0]) begin
                        success_n = 1'b1;
                        state_n   = S_DONE;
                    end else begin
                        retry_ev = 1'b1;
                    end
                end else if (timeout) begin
                    retry_ev = 1'b1;
                end
            end
            S_WAIT_DATA: begin
                if (pkt_out_avail) begin
                    if (!good) begin
                        hs_nak_n = 1'b1;
                        state_n  = S_HS;
                    end else if (pid_lo == PID_DATA0[3:0]) begin
                        data_in_n = pkt_out[DATA_HI:DATA_LO];
                        hs_nak_n  = 1'b0;
                        state_n   = S_HS;
                    end else begin
                        retry_ev = 1'b1;
                    end
                end else if (timeout) begin
                    retry_ev = 1'b1;
                end
            end
            S_HS: begin
                pkt_n      = pack_handshake(hs_nak ? PID_NAK : PID_ACK);
                avail_n    = 1'b1;
                seen_low_n = 1'b0;
                state_n    = S_HS_WAIT;
            end
            S_HS_WAIT: begin
                if (sent) begin
                    if (hs_nak) begin
                        retry_ev = 1'b1;
                    end else begin
                        success_n = 1'b1;
                        state_n   = S_DONE;
                    end
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (retry_ev) begin
            if (retry < RW'(MAX_RETRY)) begin
                retry_n = retry + RW'(1);
                state_n = S_TOK;
            end else begin
                success_n = 1'b0;
                state_n   = S_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state        <= S_IDLE;
            req_in       <= 1'b0;
            req_addr     <= '0;
            req_endp     <= '0;
            req_data     <= '0;
            retry        <= '0;
            pkt_in       <= '0;
            pkt_in_avail <= 1'b0;
            seen_low     <= 1'b0;
            hs_nak       <= 1'b0;
            txn_success  <= 1'b0;
            txn_data_in  <= '0;
        end else begin
            state        <= state_n;
            req_in       <= req_in_n;
            req_addr     <= req_addr_n;
            req_endp     <= req_endp_n;
            req_data     <= req_data_n;
            retry        <= retry_n;
            pkt_in       <= pkt_n;
            pkt_in_avail <= avail_n;
            seen_low     <= seen_low_n;
            hs_nak       <= hs_nak_n;
            txn_success  <= success_n;
            txn_data_in  <= data_in_n;
        end
    end

endmodule

// File: tb/tb_usb_host_protocol.sv
// tb_usb_host_protocol: directed transactions against encoder and device
// models; completions are checked from a scoreboard queue.
module tb_usb_host_protocol;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        txn_start;
    logic        txn_is_in;
    logic [6:0]  txn_addr;
    logic [3:0]  txn_endp;
    logic [63:0] txn_data_out;
    logic        busy;
    logic        txn_done;
    logic        txn_success;
    logic [63:0] txn_data_in;
    logic [98:0] pkt_in;
    logic        pkt_in_avail;
    logic        encoder_ready;
    logic [98:0] pkt_out;
    logic        pkt_out_avail;
    logic        data_good;
    logic        decoder_ready;
    logic        re;

    always #5 clk = ~clk;

    usb_host_protocol dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .txn_start    (txn_start),
        .txn_is_in    (txn_is_in),
        .txn_addr     (txn_addr),
        .txn_endp     (txn_endp),
        .txn_data_out (txn_data_out),
        .busy         (busy),
        .txn_done     (txn_done),
        .txn_success  (txn_success),
        .txn_data_in  (txn_data_in),
        .pkt_in       (pkt_in),
        .pkt_in_avail (pkt_in_avail),
        .encoder_ready(encoder_ready),
        .pkt_out      (pkt_out),
        .pkt_out_avail(pkt_out_avail),
        .data_good    (data_good),
        .decoder_ready(decoder_ready),
        .re           (re)
    );

    typedef struct {
        bit          success;
        bit          chk_data;
        logic [63:0] data;
    } exp_t;

    // kind: 0 silent, 1 ACK, 2 NAK, 3 DATA0 good, 4 DATA0 bad CRC,
    // 5 ACK with corrupt complement nibble
    typedef struct {
        int          kind;
        logic [63:0] data;
    } resp_t;

    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    int          viol = 0;
    exp_t        sb_q[$];
    resp_t       resp_q[$];
    logic [98:0] sent_q[$];
    int          re_runs[$];

    task automatic check(string name, logic [98:0] act,
                         logic [98:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [98:0] get_pkt(int i);
        if (i < sent_q.size()) return sent_q[i];
        return '0;
    endfunction

    function automatic int count_pid(logic [7:0] pid);
        int n = 0;
        logic [98:0] p;
        foreach (sent_q[i]) begin
            p = sent_q[i];
            if (p[98:91] == pid) n++;
        end
        return n;
    endfunction

    // encoder: accepts on avail&ready, busy for a few cycles after
    initial begin : enc_model
        int cnt;
        bit pend;
        cnt = 0;
        pend = 0;
        encoder_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (pend) begin
                encoder_ready = 1'b0;
                cnt = 4;
                pend = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) encoder_ready = 1'b1;
            end
            if (pkt_in_avail && !encoder_ready) viol++;
            if (pkt_in_avail && encoder_ready) begin
                sent_q.push_back(pkt_in);
                pend = 1;
            end
        end
    end

    // device: one scripted response per listening window
    initial begin : dev_model
        resp_t cur;
        int    dly;
        int    run;
        bit    re_prev;
        pkt_out = '0;
        pkt_out_avail = 1'b0;
        data_good = 1'b0;
        decoder_ready = 1'b1;
        cur.kind = 0;
        cur.data = '0;
        dly = 0;
        run = 0;
        re_prev = 0;
        forever begin
            @(negedge clk);
            pkt_out_avail = 1'b0;
            data_good = 1'b0;
            if (re && !re_prev) begin
                run = 0;
                dly = 2;
                if (resp_q.size() > 0) cur = resp_q.pop_front();
                else cur.kind = 0;
            end
            if (re) begin
                run++;
                if (dly > 0) begin
                    dly--;
                    if (dly == 0 && cur.kind != 0) begin
                        pkt_out_avail = 1'b1;
                        data_good = 1'b1;
                        case (cur.kind)
                            1: pkt_out = {8'hD2, 91'b0};
                            2: pkt_out = {8'h5A, 91'b0};
                            3: pkt_out = {8'hC3, cur.data, 27'b0};
                            4: begin
                                pkt_out = {8'hC3, cur.data, 27'b0};
                                data_good = 1'b0;
                            end
                            default: pkt_out = {8'hF2, 91'b0};
                        endcase
                    end
                end
            end
            if (!re && re_prev) re_runs.push_back(run);
            re_prev = re;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (txn_done) begin
                done_cnt++;
                check("busy_at_done", 99'(busy), 99'(0));
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got txn_done=1 expected none");
                end else begin
                    e = sb_q.pop_front();
                    check("txn_success", 99'(txn_success), 99'(e.success));
                    if (e.chk_data)
                        check("txn_data_in", 99'(txn_data_in), 99'(e.data));
                end
            end
        end
    end

    task automatic pulse_start(bit is_in, logic [6:0] a, logic [3:0] ep,
                               logic [63:0] d);
        @(negedge clk);
        txn_is_in = is_in;
        txn_addr = a;
        txn_endp = ep;
        txn_data_out = d;
        txn_start = 1'b1;
        @(negedge clk);
        txn_start = 1'b0;
    endtask

    task automatic start_txn(bit is_in, logic [6:0] a, logic [3:0] ep,
                             logic [63:0] d, bit exp_s, bit chk,
                             logic [63:0] exp_d);
        exp_t e;
        e.success = exp_s;
        e.chk_data = chk;
        e.data = exp_d;
        sb_q.push_back(e);
        pulse_start(is_in, a, ep, d);
    endtask

    task automatic wait_done(string name, int limit);
        int base = done_cnt;
        int n = 0;
        while (done_cnt == base && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == base) begin
            tests++;
            fails++;
            $display("FAIL %s: got no txn_done expected one within %0d cycles",
                     name, limit);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic clear_logs();
        sent_q.delete();
        re_runs.delete();
        viol = 0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int base;
        int n;
        logic [98:0] p;
        rst_b = 1'b1;
        txn_start = 1'b0;
        txn_is_in = 1'b0;
        txn_addr = '0;
        txn_endp = '0;
        txn_data_out = '0;
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        check("rst_busy", 99'(busy), 99'(0));
        check("rst_done", 99'(txn_done), 99'(0));
        check("rst_avail", 99'(pkt_in_avail), 99'(0));
        check("rst_re", 99'(re), 99'(0));
        check("rst_pkt_in", pkt_in, 99'(0));

        // OUT, device ACKs
        clear_logs();
        resp_q.push_back('{1, 64'h0});
        start_txn(0, 7'h05, 4'h1, 64'hDEADBEEF_CAFEF00D, 1, 0, 64'h0);
        wait_done("t1_done", 1000);
        check("t1_npkts", 99'(sent_q.size()), 99'(2));
        p = get_pkt(0);
        check("t1_tok_hdr", 99'(p[98:80]), 99'({8'hE1, 7'h05, 4'h1}));
        check("t1_tok", p, {8'hE1, 7'h05, 4'h1, 80'b0});
        check("t1_data", get_pkt(1),
              {8'hC3, 64'hDEADBEEF_CAFEF00D, 27'b0});
        check("t1_viol", 99'(viol), 99'(0));

        // IN, good DATA0
        clear_logs();
        resp_q.push_back('{3, 64'h0123_4567_89AB_CDEF});
        start_txn(1, 7'h12, 4'h3, 64'h0, 1, 1, 64'h0123_4567_89AB_CDEF);
        wait_done("t2_done", 1000);
        check("t2_npkts", 99'(sent_q.size()), 99'(2));
        check("t2_tok", get_pkt(0), {8'h69, 7'h12, 4'h3, 80'b0});
        check("t2_ack", get_pkt(1), {8'hD2, 91'b0});

        // IN, bad CRC then good
        clear_logs();
        resp_q.push_back('{4, 64'hFFFF_0000_FFFF_0000});
        resp_q.push_back('{3, 64'h1111_2222_3333_4444});
        start_txn(1, 7'h40, 4'hF, 64'h0, 1, 1, 64'h1111_2222_3333_4444);
        wait_done("t3_done", 2000);
        check("t3_npkts", 99'(sent_q.size()), 99'(4));
        check("t3_nak", get_pkt(1), {8'h5A, 91'b0});
        check("t3_nak_cnt", 99'(count_pid(8'h5A)), 99'(1));
        check("t3_tok2", get_pkt(2), {8'h69, 7'h40, 4'hF, 80'b0});
        check("t3_ack", get_pkt(3), {8'hD2, 91'b0});

        // OUT, device silent: 8 attempts then failure
        clear_logs();
        start_txn(0, 7'h33, 4'h2, 64'h55AA_55AA_0F0F_F0F0, 0, 0, 64'h0);
        wait_done("t4_done", 6000);
        check("t4_npkts", 99'(sent_q.size()), 99'(16));
        check("t4_tokens", 99'(count_pid(8'hE1)), 99'(8));
        check("t4_windows", 99'(re_runs.size()), 99'(8));
        n = 0;
        foreach (re_runs[i]) if (re_runs[i] == 255) n++;
        check("t4_win_len255", 99'(n), 99'(8));

        // OUT, NAK x3 then ACK; a second start while busy is ignored
        clear_logs();
        resp_q.push_back('{2, 64'h0});
        resp_q.push_back('{2, 64'h0});
        resp_q.push_back('{2, 64'h0});
        resp_q.push_back('{1, 64'h0});
        start_txn(0, 7'h22, 4'h7, 64'h0BAD_F00D_1234_5678, 1, 0, 64'h0);
        repeat (3) @(negedge clk);
        pulse_start(1, 7'h7F, 4'hE, 64'h0);
        wait_done("t5_done", 3000);
        check("t5_tokens", 99'(count_pid(8'hE1)), 99'(4));
        n = 0;
        foreach (sent_q[i]) begin
            p = sent_q[i];
            if (p[98:84] == {8'hE1, 7'h22}) n++;
        end
        check("t5_tok_addr", 99'(n), 99'(4));
        check("t5_in_tokens", 99'(count_pid(8'h69)), 99'(0));
        check("t5_viol", 99'(viol), 99'(0));

        // OUT, corrupt-complement ACK counts as a failed attempt
        clear_logs();
        resp_q.push_back('{5, 64'h0});
        resp_q.push_back('{1, 64'h0});
        start_txn(0, 7'h01, 4'h0, 64'h1, 1, 0, 64'h0);
        wait_done("t6_done", 2000);
        check("t6_tokens", 99'(count_pid(8'hE1)), 99'(2));

        // reset while waiting for IN data
        clear_logs();
        pulse_start(1, 7'h09, 4'h4, 64'h0);
        n = 0;
        while (!re && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t7_reached_wait", 99'(re), 99'(1));
        base = done_cnt;
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        check("t7_busy", 99'(busy), 99'(0));
        check("t7_done", 99'(txn_done), 99'(0));
        check("t7_re", 99'(re), 99'(0));
        check("t7_avail", 99'(pkt_in_avail), 99'(0));
        check("t7_pkt_in", pkt_in, 99'(0));
        check("t7_success", 99'(txn_success), 99'(0));
        check("t7_data_in", 99'(txn_data_in), 99'(0));
        repeat (20) @(negedge clk);
        check("t7_no_done", 99'(done_cnt), 99'(base));

        clear_logs();
        resp_q.push_back('{1, 64'h0});
        start_txn(0, 7'h0A, 4'h5, 64'hAAAA_BBBB_CCCC_DDDD, 1, 0, 64'h0);
        wait_done("t7b_done", 1000);
        check("t7b_tok", get_pkt(0), {8'hE1, 7'h0A, 4'h5, 80'b0});
        check("t7b_sb_empty", 99'(sb_q.size()), 99'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/usb_host_protocol.md
Name: usb_host_protocol

Overview:
- Host-side transaction engine sitting directly upstream of the datapath.
- Accepts one IN or OUT transaction request at a time.
- Builds 99-bit token, data and handshake packets into the datapath encoder, and interprets decoded packets coming back.
- Handles timeouts, NAK/corrupt retries and reports pass/fail to the controller above.

Parameters:
- TIMEOUT_CYC, 255, cycles to wait for a device response before declaring timeout.
- MAX_RETRY, 8, maximum attempts per transaction (first attempt included).

Ports:
- clk  input  1  system clock
- rst_b  input  1  synchronous, active-high reset (1 = reset)
- txn_start  input  1  one-cycle request pulse; honoured only when busy=0
- txn_is_in  input  1  1 = IN transaction, 0 = OUT
- txn_addr  input  7  device address
- txn_endp  input  4  endpoint
- txn_data_out  input  64  OUT payload
- busy  output  1  transaction in progress
- txn_done  output  1  one-cycle completion pulse
- txn_success  output  1  valid with txn_done: 1 = ACKed / data received
- txn_data_in  output  64  IN payload; valid when txn_done=1 and txn_success=1
- pkt_in  output  99  packet to the encoder
- pkt_in_avail  output  1  packet valid to the encoder
- encoder_ready  input  1  encoder can accept a packet
- pkt_out  input  99  decoded packet
- pkt_out_avail  input  1  one-cycle decoded-packet strobe
- data_good  input  1  CRC result, valid with pkt_out_avail
- decoder_ready  input  1  decoder idle and listening
- re  output  1  bus read enable (host listening)

Behaviour:
- Packet layout (MSB first):
  - [98:91] PID byte (low nibble PID, high nibble its complement).
  - Token: [90:84] addr, [83:80] endp.
  - Data: [90:27] payload.
  - All unused bits 0; the encoder appends the CRC.
- PIDs: OUT=8'hE1, IN=8'h69, DATA0=8'hC3, ACK=8'hD2, NAK=8'h5A. Data PID is always DATA0; there is no toggle tracking.
- Reset values: all outputs 0; state IDLE; retry count 0; timer 0. Reset asserted mid-transaction returns to IDLE at the next edge, with no txn_done pulse.
- Send handshake:
  - pkt_in and pkt_in_avail are registered and held until the first cycle where pkt_in_avail=1 and encoder_ready=1; that is the transfer cycle.
  - pkt_in_avail drops the next cycle.
  - The encoder drops encoder_ready the cycle after a transfer and holds it low until the last bit is on the wire.
  - The FSM treats a packet as sent when encoder_ready has been seen low and then high again.
- States: IDLE, TOK, TOK_WAIT, DATA, DATA_WAIT, WAIT_HS, WAIT_DATA, HS, HS_WAIT, DONE.
  - IDLE: txn_start loads the request registers, sets busy=1 and retry=1, then goes to TOK. txn_start while busy=1 is ignored.
  - TOK → TOK_WAIT: send IN/OUT token. Then go to DATA (OUT) or WAIT_DATA (IN).
  - DATA → DATA_WAIT: send DATA0 with txn_data_out, then go to WAIT_HS.
  - WAIT_HS (re=1): timer counts from 0.
    - pkt_out_avail with data_good=1 and PID ACK: success.
    - PID NAK, any other PID, data_good=0, or timer reaching TIMEOUT_CYC: retry.
  - WAIT_DATA (re=1):
    - pkt_out_avail with data_good=1 and PID DATA0: capture payload into txn_data_in, then go to HS with ACK → success.
    - PID NAK or timeout: retry.
    - data_good=0: go to HS with NAK, then retry.
  - Retry: if retry < MAX_RETRY, increment it and go to TOK; otherwise go to DONE with txn_success=0.
  - DONE: pulse txn_done for 1 cycle, clear busy, return to IDLE. txn_done and busy=0 occur in the same cycle.
- Entry into DONE:
  - Success: DONE is entered the cycle after the ACK strobe (OUT) or after the ACK has been sent (IN).
  - Failure: DONE is entered the cycle after the final failure event.
- re is asserted only in WAIT_HS and WAIT_DATA.
- Timer: 8-bit, saturating, cleared on entry to each wait state.
  - If a packet strobe and the timeout occur in the same cycle, the packet wins.
- The PID check is on the low nibble only. A PID byte whose complement nibble mismatches counts as corrupt and is treated as data_good=0.
- pkt_out_avail outside the wait states is ignored.
- decoder_ready is informational only; nothing gates on it.

Decomposition:
- Package usb_pkg:
  - PID constants.
  - Packet field index localparams.
  - Enum for FSM states.
  - Pack functions for token/data/handshake packets.
- Sub-module usb_resp_timer: 8-bit saturating counter with clear and TIMEOUT_CYC compare, reused by the device side.

Test Plan:
- OUT, addr=7'h05, endp=4'h1, data=64'hDEADBEEF_CAFEF00D; device ACKs.
  - Two packets sent: pkt_in[98:80]={8'hE1,7'h05,4'h1}, then DATA0 with the payload.
  - txn_done=1, txn_success=1.
  - pkt_in_avail never high while encoder_ready is low.
- IN, device returns DATA0 64'h0123_4567_89AB_CDEF with data_good=1.
  - Host sends ACK (pkt_in[98:91]=8'hD2).
  - txn_data_in=64'h0123_4567_89AB_CDEF, txn_success=1.
- IN with data_good=0 on the first response, good on the second.
  - NAK 8'h5A sent once, second IN token issued, success on attempt 2.
- OUT where the device never responds.
  - Exactly 8 token+data pairs are sent, each followed by 255 cycles of re=1.
  - Then txn_done=1, txn_success=0.
- OUT where the device NAKs 3 times then ACKs: success, 4 token transmissions counted.
  - Also: txn_start pulsed while busy is ignored.
- Reset asserted in WAIT_DATA.
  - Next cycle: all outputs 0, busy=0, no txn_done pulse.
  - A new txn_start after reset is accepted normally.
